// File: rtl/fuel_pkg.sv
// Shared types and constants for the fuel-pump cost display sequencer.
// Segment patterns are ordered {g,f,e,d,c,b,a}, active-high.
package fuel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int MAX_COST_DEFAULT = 99;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [6:0] SEG_DIGITS [10] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4,
    SEG_5, SEG_6, SEG_7, SEG_8, SEG_9
  };

  // tens*10 + ones using shifts only (tens*8 + tens*2 + ones).
  function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] ones);
    return 7'({tens, 3'b000}) + 7'({tens, 1'b0}) + 7'(ones);
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to seven-segment decoder; codes 10..15 are blanked.
module seg7_decoder
  import fuel_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd < 4'd10) begin
      seg = SEG_DIGITS[bcd];
    end
  end

endmodule

// File: rtl/fuel_fsm.sv
// Fuel-pump cost display sequencer: latches a clamped cost on start and counts
// a two-digit BCD display up to it, one step every TICK_DIV cycles.
module fuel_fsm
  import fuel_pkg::*;
#(
  parameter int TICK_DIV = 1,
  parameter int MAX_COST = MAX_COST_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] final_cost,
  output logic [6:0] seg_digit1,
  output logic [6:0] seg_digit2,
  output logic       done
);

  localparam int              TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [6:0]      MAX_T     = 7'(MAX_COST);

  state_t              state_reg;
  logic [3:0]          tens_reg;
  logic [3:0]          ones_reg;
  logic [6:0]          target_reg;
  logic [TICK_W-1:0]   tick_reg;

  logic [6:0]          target_next;
  logic [6:0]          count_bin;

  always_comb begin
    target_next = final_cost[6:0];
    if (final_cost > 8'(MAX_COST)) begin
      target_next = MAX_T;
    end
  end

  assign count_bin = bcd_to_bin(tens_reg, ones_reg);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      tens_reg   <= 4'd0;
      ones_reg   <= 4'd0;
      target_reg <= 7'd0;
      tick_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            target_reg <= target_next;
            tens_reg   <= 4'd0;
            ones_reg   <= 4'd0;
            tick_reg   <= '0;
            state_reg  <= COUNT;
          end
        end
        COUNT: begin
          // Compare before incrementing so the display never overshoots.
          if (count_bin == target_reg) begin
            state_reg <= DONE;
          end else if (tick_reg == TICK_LAST) begin
            tick_reg <= '0;
            if (ones_reg == 4'd9) begin
              ones_reg <= 4'd0;
              tens_reg <= tens_reg + 4'd1;
            end else begin
              ones_reg <= ones_reg + 4'd1;
            end
          end else begin
            tick_reg <= tick_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic [3:0] digit [2];
  logic [6:0] seg   [2];

  assign digit[0] = tens_reg;
  assign digit[1] = ones_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dec
      seg7_decoder u_dec (
        .bcd (digit[gi]),
        .seg (seg[gi])
      );
    end
  endgenerate

  assign seg_digit1 = seg[0];
  assign seg_digit2 = seg[1];
  assign done       = (state_reg == DONE);

endmodule

// File: tb/tb_fuel_fsm.sv
// Bench for fuel_fsm: two instances (TICK_DIV 1 and 4) checked every cycle
// against a time-based model, plus directed literal checks and random stimulus.
module tb_fuel_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] final_cost;
  logic [6:0] a_seg1, a_seg2, b_seg1, b_seg2;
  logic       a_done, b_done;

  always #5 clk = ~clk;

  fuel_fsm #(.TICK_DIV(1)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .final_cost (final_cost),
    .seg_digit1 (a_seg1),
    .seg_digit2 (a_seg2),
    .done       (a_done)
  );

  fuel_fsm #(.TICK_DIV(4)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .final_cost (final_cost),
    .seg_digit1 (b_seg1),
    .seg_digit2 (b_seg2),
    .done       (b_done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  // Model: mode 0 = idle, 1 = started; t = cycles since accepted start.
  int m_mode [2] = '{0, 0};
  int m_t    [2] = '{0, 0};
  int m_tgt  [2] = '{0, 0};
  int td     [2] = '{1, 4};

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic int clamp_cost(input logic [7:0] c);
    return (int'(c) > 99) ? 99 : int'(c);
  endfunction

  function automatic logic exp_done(input int i);
    return (m_mode[i] == 1) && (m_t[i] > m_tgt[i] * td[i]);
  endfunction

  function automatic int exp_val(input int i);
    int v;
    if (m_mode[i] == 0) return 0;
    v = m_t[i] / td[i];
    return (v > m_tgt[i]) ? m_tgt[i] : v;
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_mode[i] <= 0;
        m_t[i]    <= 0;
      end else if (m_mode[i] == 0) begin
        if (start) begin
          m_mode[i] <= 1;
          m_t[i]    <= 0;
          m_tgt[i]  <= clamp_cost(final_cost);
        end
      end else if (m_t[i] > m_tgt[i] * td[i]) begin
        if (start) begin
          m_t[i]   <= 0;
          m_tgt[i] <= clamp_cost(final_cost);
        end
      end else begin
        m_t[i] <= m_t[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_seg1", a_seg1, seg_of(exp_val(0) / 10));
      check("a_seg2", a_seg2, seg_of(exp_val(0) % 10));
      check("a_done", {6'b0, a_done}, {6'b0, exp_done(0)});
      check("b_seg1", b_seg1, seg_of(exp_val(1) / 10));
      check("b_seg2", b_seg2, seg_of(exp_val(1) % 10));
      check("b_done", {6'b0, b_done}, {6'b0, exp_done(1)});
    end
  end

  task automatic pulse(input logic [7:0] c);
    final_cost = c;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    $display("start pulse final_cost=%0d at %0t", c, $time);
  endtask

  task automatic lit_a(input string name, input logic [6:0] s1, input logic [6:0] s2, input logic d);
    check({name, "_seg1"}, a_seg1, s1);
    check({name, "_seg2"}, a_seg2, s2);
    check({name, "_done"}, {6'b0, a_done}, {6'b0, d});
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    final_cost = 8'd0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    reset  = 1'b1;
    lit_a("reset", 7'b0111111, 7'b0111111, 1'b0);
    repeat (10) @(negedge clk);
    lit_a("idle", 7'b0111111, 7'b0111111, 1'b0);

    // Count to 25 with the 09->10 carry and exact done latency.
    pulse(8'd25);
    lit_a("c25_j0", 7'b0111111, 7'b0111111, 1'b0);
    repeat (10) @(negedge clk);
    lit_a("c25_carry", 7'b0000110, 7'b0111111, 1'b0);
    repeat (15) @(negedge clk);
    lit_a("c25_j25", 7'b1011011, 7'b1101101, 1'b0);
    @(negedge clk);
    lit_a("c25_done", 7'b1011011, 7'b1101101, 1'b1);
    repeat (5) @(negedge clk);
    lit_a("c25_hold", 7'b1011011, 7'b1101101, 1'b1);

    // Zero cost: one COUNT cycle.
    pulse(8'd0);
    lit_a("c0_j0", 7'b0111111, 7'b0111111, 1'b0);
    @(negedge clk);
    lit_a("c0_done", 7'b0111111, 7'b0111111, 1'b1);

    // Over-range cost clamps to 99.
    pulse(8'd200);
    repeat (99) @(negedge clk);
    lit_a("c200_j99", 7'b1101111, 7'b1101111, 1'b0);
    @(negedge clk);
    lit_a("c200_done", 7'b1101111, 7'b1101111, 1'b1);

    // Start during COUNT is ignored; start in DONE restarts.
    pulse(8'd25);
    repeat (5) @(negedge clk);
    pulse(8'd5);
    repeat (20) @(negedge clk);
    lit_a("ign_done", 7'b1011011, 7'b1101101, 1'b1);
    pulse(8'd5);
    lit_a("re_j0", 7'b0111111, 7'b0111111, 1'b0);
    repeat (5) @(negedge clk);
    lit_a("re_j5", 7'b0111111, 7'b1101101, 1'b0);
    @(negedge clk);
    lit_a("re_done", 7'b0111111, 7'b1101101, 1'b1);

    // Reset mid-count.
    pulse(8'd30);
    repeat (12) @(negedge clk);
    lit_a("mid_j12", 7'b0000110, 7'b1011011, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    lit_a("mid_rst", 7'b0111111, 7'b0111111, 1'b0);
    pulse(8'd3);
    repeat (3) @(negedge clk);
    lit_a("after_j3", 7'b0111111, 7'b1001111, 1'b0);
    @(negedge clk);
    lit_a("after_done", 7'b0111111, 7'b1001111, 1'b1);

    // Slow instance: TICK_DIV=4, cost 3 -> done 13 cycles after start.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    pulse(8'd3);
    repeat (3) @(negedge clk);
    check("td4_j3_seg2", b_seg2, 7'b0111111);
    @(negedge clk);
    check("td4_j4_seg2", b_seg2, 7'b0000110);
    repeat (8) @(negedge clk);
    check("td4_j12_seg2", b_seg2, 7'b1001111);
    check("td4_j12_done", {6'b0, b_done}, 7'd0);
    @(negedge clk);
    check("td4_j13_done", {6'b0, b_done}, 7'd1);

    // Randomized stimulus, model-checked every cycle.
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 149) != 0);
      start      = ($urandom_range(0, 24) == 0);
      final_cost = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    start = 1'b0;
    reset = 1'b1;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
